// File: rtl/boton_eventos.sv
// rtl/boton_eventos.sv - classifies debounced button presses into short, long and auto-repeat pulses
// Starts in LOCK so a button already down at reset never produces an event.
module boton_eventos #(
  parameter int LONG_COUNT   = 10,
  parameter int REPEAT_COUNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       boton_in,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic [1:0] estado
);

  localparam int MAX_LR = (LONG_COUNT > REPEAT_COUNT) ? LONG_COUNT : REPEAT_COUNT;
  localparam int MAX_C  = (MAX_LR > 2) ? MAX_LR : 2;
  localparam int CW     = $clog2(MAX_C) + 1;

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_COUNT - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'((REPEAT_COUNT == 0) ? 0 : REPEAT_COUNT - 1);

  typedef enum logic [1:0] {
    LOCK  = 2'd0,
    IDLE  = 2'd1,
    PRESS = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  assign estado = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= LOCK;
      cnt          <= '0;
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      held         <= 1'b0;
    end else begin
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      case (state)
        LOCK: begin
          held <= 1'b0;
          cnt  <= '0;
          if (!boton_in) state <= IDLE;
        end
        IDLE: begin
          cnt <= '0;
          if (boton_in) begin
            state <= PRESS;
            held  <= 1'b1;
          end
        end
        PRESS: begin
          if (boton_in) begin
            if (cnt == LONG_LAST) begin
              long_pulse <= 1'b1;
              state      <= HOLD;
              cnt        <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            short_pulse <= 1'b1;
            held        <= 1'b0;
            state       <= IDLE;
            cnt         <= '0;
          end
        end
        HOLD: begin
          if (boton_in) begin
            // With repeat disabled the counter parks at zero for the whole hold.
            if (REPEAT_COUNT == 0) begin
              cnt <= '0;
            end else if (cnt == REP_LAST) begin
              repeat_pulse <= 1'b1;
              cnt          <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            held  <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= LOCK;
          cnt   <= '0;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boton_eventos.sv
// tb/tb_boton_eventos.sv - directed-vector bench for boton_eventos
// A second instance runs with REPEAT_COUNT=0 on the same stimulus.
module tb_boton_eventos;

  logic       clk = 1'b0;
  logic       reset;
  logic       boton_in;
  logic       short_pulse, long_pulse, repeat_pulse, held;
  logic [1:0] estado;
  logic       short2, long2, repeat2, held2;
  logic [1:0] estado2;

  int vectors     = 0;
  int miscompares = 0;

  int n_short, n_long, n_rep, e_short, e_long, e_rep_first, e_rep_last;
  int n_long2, n_rep2, e_long2;
  int held_err, excl_err, estado_err;

  always #5 clk = ~clk;

  boton_eventos #(.LONG_COUNT(10), .REPEAT_COUNT(4)) dut (
    .clk(clk), .reset(reset), .boton_in(boton_in),
    .short_pulse(short_pulse), .long_pulse(long_pulse), .repeat_pulse(repeat_pulse),
    .held(held), .estado(estado)
  );

  boton_eventos #(.LONG_COUNT(10), .REPEAT_COUNT(0)) dut_norep (
    .clk(clk), .reset(reset), .boton_in(boton_in),
    .short_pulse(short2), .long_pulse(long2), .repeat_pulse(repeat2),
    .held(held2), .estado(estado2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic b);
    boton_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats;
    n_short = 0; n_long = 0; n_rep = 0;
    e_short = -1; e_long = -1; e_rep_first = -1; e_rep_last = -1;
    n_long2 = 0; n_rep2 = 0; e_long2 = -1;
    held_err = 0; estado_err = 0;
  endtask

  task automatic record(input int e, input logic exp_held);
    if (short_pulse)  begin n_short++; e_short = e; end
    if (long_pulse)   begin n_long++;  e_long  = e; end
    if (repeat_pulse) begin
      n_rep++;
      if (e_rep_first < 0) e_rep_first = e;
      e_rep_last = e;
    end
    if (long2)   begin n_long2++; e_long2 = e; end
    if (repeat2) n_rep2++;
    if (held !== exp_held) held_err++;
    if (int'(short_pulse) + int'(long_pulse) + int'(repeat_pulse) > 1) excl_err++;
    if (int'(short2) + int'(long2) + int'(repeat2) > 1) excl_err++;
  endtask

  // Edge i samples boton_in = (i < nhigh); edge 0 is the first high sample in IDLE.
  task automatic press(input int nhigh);
    clear_stats();
    for (int i = 0; i <= nhigh; i++) begin
      step(i < nhigh);
      record(i, i < nhigh);
    end
  endtask

  initial begin
    excl_err = 0;
    clear_stats();
    reset = 1'b1;
    boton_in = 1'b0;
    step(1'b0);
    step(1'b0);
    check("rst_estado", estado, 0);
    check("rst_outputs", {short_pulse, long_pulse, repeat_pulse, held}, 0);
    reset = 1'b0;
    step(1'b0);
    check("lock_to_idle", estado, 1);

    press(3);
    check("short_count", n_short, 1);
    check("short_edge", e_short, 3);
    check("short_no_long_rep", n_long + n_rep, 0);
    check("short_held", held_err, 0);
    check("short_estado", estado, 1);

    press(20);
    check("long_count", n_long, 1);
    check("long_edge", e_long, 10);
    check("rep_count", n_rep, 2);
    check("rep_first", e_rep_first, 14);
    check("rep_last", e_rep_last, 18);
    check("long_no_short", n_short, 0);
    check("long_held", held_err, 0);
    check("long_estado", estado, 1);
    check("norep_long_edge", e_long2, 10);
    check("norep_rep_count", n_rep2, 0);

    press(10);
    check("b10_short_edge", e_short, 10);
    check("b10_no_long", n_long, 0);

    press(11);
    check("b11_long_edge", e_long, 10);
    check("b11_no_short", n_short, 0);
    check("b11_no_rep", n_rep, 0);

    // Button already down across reset must stay locked out.
    boton_in = 1'b1;
    reset = 1'b1;
    step(1'b1);
    step(1'b1);
    reset = 1'b0;
    clear_stats();
    for (int i = 0; i < 30; i++) begin
      step(1'b1);
      record(i, 1'b0);
      if (estado !== 2'd0) estado_err++;
    end
    check("lock_no_events", n_short + n_long + n_rep, 0);
    check("lock_held", held_err, 0);
    check("lock_estado", estado_err, 0);
    step(1'b0);
    check("lock_release_estado", estado, 1);
    press(3);
    check("after_lock_short", n_short, 1);
    check("after_lock_short_edge", e_short, 3);

    // Reset at edge 12 of a long hold.
    clear_stats();
    for (int i = 0; i < 12; i++) begin
      step(1'b1);
      record(i, 1'b1);
    end
    check("midhold_long_edge", e_long, 10);
    reset = 1'b1;
    step(1'b1);
    check("midhold_rst_estado", estado, 0);
    check("midhold_rst_outputs", {short_pulse, long_pulse, repeat_pulse, held}, 0);
    reset = 1'b0;
    clear_stats();
    for (int i = 0; i < 20; i++) begin
      step(1'b1);
      record(i, 1'b0);
    end
    check("midhold_no_events", n_short + n_long + n_rep, 0);
    check("midhold_held", held_err, 0);
    step(1'b0);
    press(3);
    check("midhold_new_short", n_short, 1);

    press(40);
    check("h40_long_edge", e_long, 10);
    check("h40_rep_count", n_rep, 7);
    check("h40_rep_last", e_rep_last, 38);
    check("h40_norep_long", n_long2, 1);
    check("h40_norep_long_edge", e_long2, 10);
    check("h40_norep_rep", n_rep2, 0);

    check("pulse_exclusive", excl_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
